fact_cu: RTL and testbench
==========================

// Module: fact_cu
// PURPOSE
//  Moore control unit that sequences the factorial datapath (down counter, product register, gt compares).
//  Takes a level go/n request, drives the datapath control strobes and reports done/err/busy.
//  Sits beside the datapath under the factorial top; the requester holds n stable from go until done/err.
// PARAMETERS
//  CNT_W  8  width of optional busy-cycle counter (FACT_CU_CYCLE_CNT_EN only)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  go         in   1      request level; sampled in IDLE, must drop to release DONE/ERR
//  gt_in      in   1      from datapath: n > 12 (input out of range)
//  gt_fact    in   1      from datapath: current count > 1
//  load_cnt   out  1      load down counter with n
//  en         out  1      decrement down counter
//  sel_1      out  1      product mux: 1=multiply result, 0=constant 1
//  load_reg   out  1      product register write enable
//  sel_2      out  1      output mux: 1=product to nf, 0=zero
//  busy       out  1      high in LOAD/CHECK/MULT
//  done       out  1      high in DONE (result valid on nf)
//  err        out  1      high in ERR (n > 12, no computation)
//  cycle_cnt  out  CNT_W  busy-cycle count of last/current job (0 when macro off)
// BEHAVIOUR
//  Reset: state=IDLE asynchronously; all outputs 0; cycle_cnt=0. Outputs decoded from state only.
//  States / outputs (unlisted = 0):
//   IDLE : none.  go&gt_in -> ERR; go&!gt_in -> LOAD; else IDLE.
//   LOAD : load_cnt=1, load_reg=1, sel_1=0 (cnt<=n, prod<=1), busy. -> CHECK.
//   CHECK: busy. gt_fact -> MULT; else -> DONE.
//   MULT : sel_1=1, load_reg=1, en=1 (prod<=prod*cnt, cnt<=cnt-1 same edge), busy. -> CHECK.
//   DONE : sel_2=1, done=1. !go -> IDLE; go held -> stay.
//   ERR  : err=1, sel_2=0. !go -> IDLE; go held -> stay.
//  Latency: done asserts 2*max(n,1)+1 cycles after the edge sampling go in IDLE; err 1 cycle after.
//  n=0 and n=1 both yield nf=1 (LOAD, CHECK, DONE).
//  go deasserted mid-job: ignored; job completes to DONE, then IDLE next cycle (go already low).
//  Next job requires go low for >=1 cycle (IDLE visit); no back-to-back without a gap.
//  rst_n low mid-job: immediate IDLE, strobes 0; datapath registers keep stale values (next LOAD reinits).
//  Illegal state encoding -> IDLE (default branch).
// CONFIGURATION
//  FACT_CU_CYCLE_CNT_EN defined: cycle_cnt clears on IDLE->LOAD, increments each busy cycle,
//   saturates at 2**CNT_W-1, holds in DONE/ERR/IDLE until next LOAD.
//  Not defined: no counter flops; cycle_cnt tied to 0.
// STRUCTURE
//  fact_pkg: typedef enum logic [2:0] {IDLE,LOAD,CHECK,MULT,DONE,ERR} fact_state_t; localparam MAX_N=12.
//  Single module: state register + next-state always_comb + output decode; no sub-module.
//  Datapath instantiated by the parent, not here.
// TESTING (bench pairs fact_cu with the datapath)
//  n=5, go high -> done after 11 cycles, nf=120, busy high 10 cycles, en pulsed 4 times.
//  n=0 then n=1 -> done after 3 cycles each, nf=1, en never asserted.
//  n=13, go -> err next cycle, load_cnt/load_reg never pulse, nf=0; drop go -> IDLE.
//  n=12 -> nf=479001600 after 25 cycles; go held 5 extra cycles -> done stays high, then drops 1 cycle after go low.
//  rst_n low during MULT of n=6 -> all outputs 0 same cycle; restart n=4 -> nf=24.
//  FACT_CU_CYCLE_CNT_EN, CNT_W=4, n=12 -> cycle_cnt saturates at 15; n=3 next -> cycle_cnt=6.

Source files
------------

// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - state encoding, control-strobe bundle and Moore output decode for fact_cu
package fact_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        MULT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } fact_state_t;

    localparam int MAX_N = 12;

    typedef struct packed {
        logic load_cnt;
        logic en;
        logic sel_1;
        logic load_reg;
        logic sel_2;
        logic busy;
        logic done;
        logic err;
    } fact_ctl_t;

    // Strobes depend on state alone; unlisted states leave everything low.
    function automatic fact_ctl_t ctl_decode(fact_state_t s);
        fact_ctl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.load_cnt = 1'b1;
                c.load_reg = 1'b1;
                c.busy     = 1'b1;
            end
            CHECK: c.busy = 1'b1;
            MULT: begin
                c.sel_1    = 1'b1;
                c.load_reg = 1'b1;
                c.en       = 1'b1;
                c.busy     = 1'b1;
            end
            DONE: begin
                c.sel_2 = 1'b1;
                c.done  = 1'b1;
            end
            ERR:     c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fact_cu_if.sv
// rtl/fact_cu_if.sv - request/status and datapath control bundle between fact_cu and its surroundings
interface fact_cu_if #(
    parameter int CNT_W = 8
);
    logic             go;
    logic             gt_in;
    logic             gt_fact;
    logic             load_cnt;
    logic             en;
    logic             sel_1;
    logic             load_reg;
    logic             sel_2;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output go, gt_in, gt_fact,
        input  load_cnt, en, sel_1, load_reg, sel_2, busy, done, err, cycle_cnt
    );

    modport slave (
        input  go, gt_in, gt_fact,
        output load_cnt, en, sel_1, load_reg, sel_2, busy, done, err, cycle_cnt
    );
endinterface

// File: rtl/fact_cu.sv
// rtl/fact_cu.sv - Moore control unit sequencing the factorial datapath; FACT_CU_CYCLE_CNT_EN adds a busy-cycle counter
module fact_cu
    import fact_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    fact_cu_if.slave bus
);

    fact_state_t state_q, state_d;
    fact_ctl_t   ctl_q, ctl_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.go && bus.gt_in)
                    state_d = ERR;
                else if (bus.go)
                    state_d = LOAD;
                else
                    state_d = IDLE;
            end
            LOAD:  state_d = CHECK;
            CHECK: state_d = bus.gt_fact ? MULT : DONE;
            MULT:  state_d = CHECK;
            DONE:  state_d = bus.go ? DONE : IDLE;
            ERR:   state_d = bus.go ? ERR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the registered copy tracks state_q exactly.
    always_comb begin
        ctl_d = ctl_decode(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    assign bus.load_cnt = ctl_q.load_cnt;
    assign bus.en       = ctl_q.en;
    assign bus.sel_1    = ctl_q.sel_1;
    assign bus.load_reg = ctl_q.load_reg;
    assign bus.sel_2    = ctl_q.sel_2;
    assign bus.busy     = ctl_q.busy;
    assign bus.done     = ctl_q.done;
    assign bus.err      = ctl_q.err;

`ifdef FACT_CU_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;

    // The LOAD cycle itself counts, so a fresh job starts at 1.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && state_d == LOAD)
            cyc_d = CNT_W'(1);
        else if (ctl_d.busy && (cyc_q != {CNT_W{1'b1}}))
            cyc_d = cyc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc_q <= '0;
        else
            cyc_q <= cyc_d;
    end

    assign bus.cycle_cnt = cyc_q;
`else
    assign bus.cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_fact_cu.sv
// tb/tb_fact_cu.sv - scoreboard bench for fact_cu with a behavioural factorial datapath
module tb_fact_cu;
    import fact_pkg::*;

    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    fact_cu_if #(.CNT_W(CNT_W)) bus ();

    fact_cu #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  n_r;
    logic [7:0]  cnt_r;
    logic [31:0] prod_r;
    logic [31:0] nf;

    always @(posedge clk) begin
        if (bus.load_cnt)
            cnt_r <= n_r;
        else if (bus.en)
            cnt_r <= cnt_r - 8'd1;
        if (bus.load_reg)
            prod_r <= bus.sel_1 ? prod_r * {24'd0, cnt_r} : 32'd1;
    end

    assign bus.gt_in   = (int'(n_r) > MAX_N);
    assign bus.gt_fact = (cnt_r > 8'd1);
    assign nf          = bus.sel_2 ? prod_r : 32'd0;

    typedef struct {
        int          due_cyc;
        logic [31:0] nf;
        int          en_n;
        int          busy_n;
        int          load_n;
        bit          is_err;
        int          ccnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int max1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    task automatic run_job(input int n, input logic [31:0] nf_exp, input int hold);
        exp_t e;
        int   m;
        @(negedge clk);
        m = max1(n);
        n_r    = 8'(n);
        bus.go = 1'b1;
        e.is_err = (n > 12);
        e.nf     = nf_exp;
        if (e.is_err) begin
            e.due_cyc = cyc + 1;
            e.en_n = 0; e.busy_n = 0; e.load_n = 0; e.ccnt = -1;
        end else begin
            e.due_cyc = cyc + 2 * m + 1;
            e.en_n    = m - 1;
            e.busy_n  = 2 * m;
            e.load_n  = m;
`ifdef FACT_CU_CYCLE_CNT_EN
            e.ccnt    = (2 * m > 15) ? 15 : 2 * m;
`else
            e.ccnt    = 0;
`endif
        end
        exp_q.push_back(e);
        for (int i = 0; i < 200 && !(bus.done || bus.err); i++) @(negedge clk);
        check("job_end", longint'(bus.done | bus.err), 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_status", longint'(bus.done | bus.err), 1);
        end
        bus.go = 1'b0;
        @(negedge clk);
        check("release", longint'({bus.done, bus.err, bus.busy}), 0);
    endtask

    int en_acc, busy_acc, load_acc;
    bit ev_prev;

    initial begin
        exp_t e;
        en_acc = 0; busy_acc = 0; load_acc = 0; ev_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                en_acc = 0; busy_acc = 0; load_acc = 0; ev_prev = 1'b0;
            end else begin
                en_acc   += int'(bus.en);
                busy_acc += int'(bus.busy);
                load_acc += int'(bus.load_cnt | bus.load_reg);
                if ((bus.done || bus.err) && !ev_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency_cycle", cyc, e.due_cyc);
                        check("err_flag", longint'(bus.err), longint'(e.is_err));
                        check("done_flag", longint'(bus.done), longint'(!e.is_err));
                        check("nf", longint'(nf), longint'(e.nf));
                        check("en_pulses", en_acc, e.en_n);
                        check("busy_cycles", busy_acc, e.busy_n);
                        check("load_pulses", load_acc, e.load_n);
                        if (e.ccnt >= 0)
                            check("cycle_cnt", longint'(bus.cycle_cnt), e.ccnt);
                    end
                    en_acc = 0; busy_acc = 0; load_acc = 0;
                end
                ev_prev = bus.done || bus.err;
            end
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus.go = 1'b0;
        n_r    = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", longint'({bus.load_cnt, bus.en, bus.sel_1, bus.load_reg,
                                          bus.sel_2, bus.busy, bus.done, bus.err}), 0);
        check("reset_cycle_cnt", longint'(bus.cycle_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(5, 32'd120, 0);
        run_job(0, 32'd1, 0);
        run_job(1, 32'd1, 0);
        run_job(13, 32'd0, 2);
        run_job(12, 32'd479001600, 5);
        run_job(3, 32'd6, 0);

        @(negedge clk);
        n_r    = 8'd6;
        bus.go = 1'b1;
        for (int i = 0; i < 50 && !bus.en; i++) @(negedge clk);
        check("reach_mult", longint'(bus.en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", longint'({bus.load_cnt, bus.en, bus.sel_1, bus.load_reg,
                                                bus.sel_2, bus.busy, bus.done, bus.err}), 0);
        check("async_reset_cycle_cnt", longint'(bus.cycle_cnt), 0);
        bus.go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(4, 32'd24, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
